// File: rtl/zled_pkg.sv
// rtl/zled_pkg.sv - shared mode encoding and per-channel update helpers for the LED array reactor
package zled_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t LED_MODE_LEVEL  = 2'd0;
  localparam led_mode_t LED_MODE_TOGGLE = 2'd1;
  localparam led_mode_t LED_MODE_BLINK  = 2'd2;
  localparam led_mode_t LED_MODE_OFF    = 2'd3;

  // Down has priority over up; a mode change wins over both and drops the events.
  function automatic logic nextState(
    input led_mode_t mode,
    input logic      modeChanged,
    input logic      state,
    input logic      downEv,
    input logic      upEv
  );
    logic result;
    result = state;
    if (modeChanged) begin
      result = 1'b0;
    end else begin
      case (mode)
        LED_MODE_LEVEL, LED_MODE_BLINK: begin
          if (downEv)    result = 1'b1;
          else if (upEv) result = 1'b0;
        end
        LED_MODE_TOGGLE: begin
          if (downEv) result = ~state;
        end
        default: result = 1'b0;
      endcase
    end
    return result;
  endfunction

  function automatic logic ledLit(
    input led_mode_t mode,
    input logic      state,
    input logic      phase
  );
    logic result;
    case (mode)
      LED_MODE_LEVEL, LED_MODE_TOGGLE: result = state;
      LED_MODE_BLINK:                  result = state & phase;
      default:                         result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/zled_debounce.sv
// rtl/zled_debounce.sv - one-bit 2-flop synchroniser, debouncer and stable rising-edge pulse
module zled_debounce
  import zled_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic iClk,
  input  logic iRstN,
  input  logic iRaw,
  output logic oRise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stableD;
  logic [CW-1:0] cnt;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stable  <= 1'b0;
      stableD <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= iRaw;
      sync2   <= sync1;
      stableD <= stable;
      // Any cycle of agreement restarts the interval, so short glitches never commit.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign oRise = stable & ~stableD;

endmodule

// File: rtl/zled_array_reactor.sv
// rtl/zled_array_reactor.sv - N_CH switch-pair driven LEDs with level/toggle/blink/off modes
module zled_array_reactor
  import zled_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_HALF = 25000000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic [N_CH-1:0]   iSwDown,
  input  logic [N_CH-1:0]   iSwUp,
  input  logic [2*N_CH-1:0] iMode,
  output logic [N_CH-1:0]   oLed,
  output logic [N_CH-1:0]   oPress
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);
  localparam logic LED_OFF = (ACTIVE_LOW != 0);

  logic [N_CH-1:0]   downEv;
  logic [N_CH-1:0]   upEv;
  logic [2*N_CH-1:0] modeQ;
  logic [N_CH-1:0]   stateQ;
  logic [N_CH-1:0]   stateNext;
  logic [N_CH-1:0]   litNext;
  logic [BW-1:0]     blinkCnt;
  logic              blinkPhase;
  logic              blinkWrap;
  logic              phaseNext;

  for (genvar c = 0; c < N_CH; c++) begin : gCh
    zled_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebDown (
      .iClk  (iClk),
      .iRstN (iRstN),
      .iRaw  (iSwDown[c]),
      .oRise (downEv[c])
    );
    zled_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebUp (
      .iClk  (iClk),
      .iRstN (iRstN),
      .iRaw  (iSwUp[c]),
      .oRise (upEv[c])
    );
  end

  always_comb begin
    blinkWrap = (blinkCnt == BLINK_MAX);
    phaseNext = blinkPhase ^ blinkWrap;
  end

  // The LED register is fed from next-state so oLed moves on the same edge as the state.
  always_comb begin
    stateNext = '0;
    litNext   = '0;
    for (int c = 0; c < N_CH; c++) begin
      stateNext[c] = nextState(iMode[2*c +: 2], iMode[2*c +: 2] != modeQ[2*c +: 2],
                               stateQ[c], downEv[c], upEv[c]);
      litNext[c]   = ledLit(iMode[2*c +: 2], stateNext[c], phaseNext);
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      modeQ      <= '0;
      stateQ     <= '0;
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
      oPress     <= '0;
      oLed       <= {N_CH{LED_OFF}};
    end else begin
      modeQ      <= iMode;
      stateQ     <= stateNext;
      blinkCnt   <= blinkWrap ? '0 : blinkCnt + 1'b1;
      blinkPhase <= phaseNext;
      oPress     <= downEv;
      oLed       <= litNext ^ {N_CH{LED_OFF}};
    end
  end

endmodule

// File: tb/tb_zled_array_reactor.sv
// tb/tb_zled_array_reactor.sv - directed self-checking bench for zled_array_reactor
module tb_zled_array_reactor;

  logic       clk;
  logic       rstN;
  logic [3:0] swDown;
  logic [3:0] swUp;
  logic [7:0] mode;
  logic [3:0] led;
  logic [3:0] press;
  logic [3:0] ledAl;
  logic [3:0] pressAl;

  int nChecks = 0;
  int nPass   = 0;

  zled_array_reactor #(
    .N_CH(4), .DEB_CYCLES(4), .BLINK_HALF(8), .ACTIVE_LOW(0)
  ) uDut (
    .iClk(clk), .iRstN(rstN), .iSwDown(swDown), .iSwUp(swUp),
    .iMode(mode), .oLed(led), .oPress(press)
  );

  zled_array_reactor #(
    .N_CH(4), .DEB_CYCLES(4), .BLINK_HALF(8), .ACTIVE_LOW(1)
  ) uDutAl (
    .iClk(clk), .iRstN(rstN), .iSwDown(swDown), .iSwUp(swUp),
    .iMode(mode), .oLed(ledAl), .oPress(pressAl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_sw(input logic [3:0] dn, input logic [3:0] up, output int pulses);
    pulses = 0;
    swDown = swDown | dn;
    swUp   = swUp | up;
    repeat (12) begin
      step();
      pulses += $countones(press & dn);
    end
    swDown = swDown & ~dn;
    swUp   = swUp & ~up;
    repeat (12) begin
      step();
      pulses += $countones(press & dn);
    end
  endtask

  initial begin
    int pulses;
    int found;
    int highs;
    logic prev;
    logic expBit;

    rstN = 1'b0; swDown = '0; swUp = '0; mode = '0;
    repeat (3) step();
    chk("rst oLed in reset", led, 4'b0000);
    chk("rst oLed AL in reset", ledAl, 4'b1111);
    rstN = 1'b1;
    repeat (3) step();
    chk("idle oLed", led, 4'b0000);
    chk("idle oPress", press, 4'b0000);
    chk("idle oLed AL", ledAl, 4'b1111);

    // Mode 0 set: press and LED move exactly 7 edges after first sampling edge
    swDown[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("m0 down oPress k=%0d", k), press, (k == 7) ? 4'b0001 : 4'b0000);
      chk($sformatf("m0 down oLed k=%0d", k), led, (k >= 7) ? 4'b0001 : 4'b0000);
    end
    chk("m0 lit oLed AL", ledAl, 4'b1110);
    swDown[0] = 1'b0;
    repeat (10) step();
    chk("m0 release keeps lit", led, 4'b0001);
    swUp[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("m0 up oLed k=%0d", k), led, (k < 7) ? 4'b0001 : 4'b0000);
      chk($sformatf("m0 up oPress k=%0d", k), press, 4'b0000);
    end
    swUp[0] = 1'b0;
    repeat (10) step();

    // Glitch rejection on channel 1
    for (int g = 0; g < 5; g++) begin
      swDown[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("glitch oPress", press, 4'b0000);
        chk("glitch oLed", led, 4'b0000);
      end
      swDown[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("glitch oPress", press, 4'b0000);
        chk("glitch oLed", led, 4'b0000);
      end
    end
    repeat (6) step();
    chk("glitch settled oLed", led, 4'b0000);
    pulses = 0;
    swDown[1] = 1'b1;
    repeat (10) begin
      step();
      pulses += $countones(press);
    end
    swDown[1] = 1'b0;
    repeat (15) begin
      step();
      pulses += $countones(press);
    end
    chk("long pulse press count", pulses, 1);
    chk("long pulse oLed", led, 4'b0010);

    // Mode 1 toggle on channel 2
    mode[5:4] = 2'd1;
    repeat (2) step();
    press_sw(4'b0100, 4'b0000, pulses);
    chk("tog1 oLed2", led[2], 1'b1);
    press_sw(4'b0100, 4'b0000, pulses);
    chk("tog2 oLed2", led[2], 1'b0);
    press_sw(4'b0100, 4'b0000, pulses);
    chk("tog3 oLed2", led[2], 1'b1);
    press_sw(4'b0100, 4'b0100, pulses);
    chk("tog both oLed2", led[2], 1'b0);
    chk("tog both press count", pulses, 1);

    // Blink on channels 0 and 3, the others forced off
    mode = 8'b10_11_11_10;
    repeat (2) step();
    chk("blink setup oLed", led, 4'b0000);
    press_sw(4'b1001, 4'b0000, pulses);
    chk("blink press count", pulses, 2);
    found = 0;
    prev = led[0];
    for (int k = 0; k < 40 && found == 0; k++) begin
      step();
      if (prev == 1'b1 && led[0] == 1'b0) found = 1;
      prev = led[0];
    end
    chk("blink falling edge found", found, 1);
    for (int j = 0; j < 16; j++) begin
      expBit = (j >= 8);
      chk($sformatf("blink ch0 j=%0d", j), led[0], expBit);
      chk($sformatf("blink ch3 j=%0d", j), led[3], expBit);
      step();
    end
    press_sw(4'b0000, 4'b1000, pulses);
    highs = 0;
    for (int j = 0; j < 16; j++) begin
      step();
      chk("blink ch3 off", led[3], 1'b0);
      highs += led[0];
    end
    chk("blink ch0 high count", highs, 8);

    // Mode switch clears state, forced off still pulses oPress
    mode = 8'h00;
    repeat (2) step();
    chk("mode back oLed", led, 4'b0000);
    press_sw(4'b0001, 4'b0000, pulses);
    chk("relit oLed0", led[0], 1'b1);
    mode[1:0] = 2'd3;
    step();
    chk("forced off next cycle", led[0], 1'b0);
    press_sw(4'b0001, 4'b0000, pulses);
    chk("forced off press count", pulses, 1);
    chk("forced off oLed0", led[0], 1'b0);
    mode[1:0] = 2'd0;
    repeat (3) step();
    chk("return mode0 oLed0", led[0], 1'b0);

    // Reset mid-debounce restarts the whole interval
    swDown[0] = 1'b1;
    repeat (4) step();
    chk("mid debounce no press", press, 4'b0000);
    rstN = 1'b0;
    step();
    chk("mid reset oLed", led, 4'b0000);
    rstN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("post rst oPress k=%0d", k), press, (k == 7) ? 4'b0001 : 4'b0000);
      chk($sformatf("post rst oLed k=%0d", k), led[0], (k >= 7));
    end
    swDown[0] = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/zled_array_reactor.md
Name: zled_array_reactor

Overview:
- Multi-channel successor to the single switch-driven LED reactor.
- Drives N_CH LEDs from N_CH pairs of raw push-switch inputs (down/up). Each input pair is synchronised and debounced, then converted to one-cycle press events.
- Each channel applies a run-time selectable mode: set/clear, toggle, blink or forced-off.
- Sits between the board switch pins and the LED pins in the fabric top level.

Parameters:
- N_CH, 4, number of LED channels (1..32).
- DEB_CYCLES, 16, number of consecutive cycles a synchronised input must differ from its stable value before the stable value updates (>=2).
- BLINK_HALF, 25000000, cycles per blink half-period, shared by all channels (>=2).
- ACTIVE_LOW, 0, 1 means the oLed pin level is inverted (LED lit when the pin is low).

Ports:
- iClk, input, 1, system clock; all logic is in this single domain.
- iRstN, input, 1, reset: asynchronous assert, active-low.
- iSwDown, input, N_CH, raw asynchronous "down" switch per channel.
- iSwUp, input, N_CH, raw asynchronous "up" switch per channel.
- iMode, input, 2*N_CH, per-channel mode; bits [2c+1:2c] belong to channel c; synchronous to iClk.
- oLed, output, N_CH, LED drive per channel, polarity set by ACTIVE_LOW.
- oPress, output, N_CH, one-cycle pulse on each debounced iSwDown rising edge.

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous and active-low on iRstN. All flops are cleared by reset.
- Reset values:
  - Synchronisers, stable values, debounce counters, channel state, blink counter and blink phase all reset to 0.
  - oPress resets to 0.
  - oLed resets to the unlit level: 0 if ACTIVE_LOW=0, else all ones.
- Reset mid-operation: reset aborts any debounce in progress and any blink phase. After release, a switch that is still held produces a press event only after a full debounce interval.
- Synchroniser: 2-flop synchroniser on every raw input bit.
- Debounce, per input bit:
  - The counter increments while the synchronised value differs from the stable value, and clears to 0 when they are equal.
  - When the counter reaches DEB_CYCLES-1 while the values still differ, the stable value takes the synchronised value and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles never reach the stable value.
- Events: downEv/upEv equal stable rising edge, i.e. stable & ~stable_d. Each is a one-cycle pulse registered into oPress and into the channel state at the same edge.
- Latency: an input held constant moves oPress/oLed exactly 2+DEB_CYCLES+1 iClk edges after its first sampling edge.
- Mode 0, set/clear: downEv sets state to 1; upEv clears it to 0.
- Mode 1, toggle: downEv inverts state; upEv is ignored.
- Mode 2, blink: downEv sets state to 1 (blinking); upEv clears it to 0.
- Mode 3, forced off: state is held at 0 and events are ignored. oPress still pulses.
- Simultaneous downEv and upEv in the same cycle: down has priority (set in mode 0/2, toggle in mode 1).
- Mode change: any cycle where a channel's iMode differs from its registered copy clears that channel's state to 0. Events arriving in that same cycle are discarded.
- Blink generator:
  - Free-running counter 0..BLINK_HALF-1; wrap-around toggles the shared phase.
  - The counter is global, so all blinking channels are phase-locked.
- LED output:
  - lit = state in modes 0 and 1; lit = state & phase in mode 2; lit = 0 in mode 3.
  - oLed = lit XOR ACTIVE_LOW, registered.
- Width rules:
  - Debounce counter width is $clog2(DEB_CYCLES); the blink counter width is $clog2(BLINK_HALF).
  - No overflow is possible, because both counters clear at their terminal count.

Decomposition:
- Shared package zled_pkg:
  - mode constants LED_MODE_LEVEL=2'd0, LED_MODE_TOGGLE=2'd1, LED_MODE_BLINK=2'd2, LED_MODE_OFF=2'd3;
  - typedef led_mode_t (2-bit).
- Sub-module zled_debounce: one bit containing the synchroniser, counter, stable value and rising-edge pulse output.
  - Instantiated 2*N_CH times via generate.
  - The top level holds the mode registers, channel state, blink generator and output register.

Test Plan (N_CH=4, DEB_CYCLES=4, BLINK_HALF=8, ACTIVE_LOW=0 unless stated):
- Reset, then hold iRstN=1 with all inputs 0 -> oLed=4'b0000, oPress=0. Repeat with ACTIVE_LOW=1 -> oLed=4'b1111.
- Mode 0 on channel 0: raise iSwDown[0] and hold -> oPress[0] pulses for exactly 1 cycle and oLed[0]=1, both 7 edges after the first sampling edge. Then raise iSwUp[0] -> oLed[0]=0 after 7 edges.
- Glitch rejection: 3-cycle pulses on iSwDown[1] repeated 5 times -> oPress=0 and oLed=0 throughout. Then a 10-cycle pulse -> exactly one oPress[1] pulse.
- Mode 1 on channel 2: three debounced presses -> oLed[2] goes 1,0,1. Simultaneous down+up press -> one toggle only.
- Mode 2 on channels 0 and 3, pressing both down -> both oLed bits square-wave, 8 cycles high / 8 cycles low, in phase. Press up on channel 3 -> oLed[3] held 0 while channel 0 keeps blinking.
- Mode switch and reset: with channel 0 lit in mode 0, change iMode to 3 -> oLed[0]=0 next cycle and a press still pulses oPress[0]. Return to mode 0 -> oLed[0] stays 0. Assert iRstN mid-debounce (counter=2) -> no event after release until 4 full stable cycles.
